auth_cmd_rx: RTL and testbench

AUTH_CMD_RX -- requirements
Module: auth_cmd_rx

---
 rtl/auth_pkg.sv | 16 +
 rtl/auth_rx_sync.sv | 21 ++
 rtl/auth_cmd_rx.sv | 137 +++++++++++++
 tb/tb_auth_cmd_rx.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/auth_pkg.sv
// auth_pkg: receiver state encoding, default baud divisor and the command codes
// shared between auth_cmd_rx and the downstream auth FSM.
package auth_pkg;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_e;

    localparam int BAUD_DIV_DEFAULT = 2604;

    localparam logic [7:0] AUTH_GO   = 8'h47;
    localparam logic [7:0] AUTH_STOP = 8'h53;

    function automatic logic is_auth_cmd(input logic [7:0] b);
        return (b == AUTH_GO) || (b == AUTH_STOP);
    endfunction

endpackage

// File: rtl/auth_rx_sync.sv
// auth_rx_sync: two-flop synchronizer for the serial line; presets high so an
// idle line never looks like a start bit coming out of reset.
module auth_rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic [1:0] ff_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ff_q <= 2'b11;
        else
            ff_q <= {ff_q[0], d_i};
    end

    assign q_o = ff_q[1];

endmodule

// File: rtl/auth_cmd_rx.sv
// auth_cmd_rx: 8N1 UART receiver delivering command bytes with a rdy/clr_rdy handshake.
// Define FRM_ERR_EN to drop bytes with a bad stop bit and expose the frm_err pulse.
module auth_cmd_rx
    import auth_pkg::*;
#(
    parameter int BAUD_DIV = BAUD_DIV_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       RX,
    input  logic       clr_rdy,
    output logic [7:0] rx_data,
    output logic       rdy
`ifdef FRM_ERR_EN
    ,
    output logic       frm_err
`endif
);

    localparam logic [11:0] HALF = 12'(BAUD_DIV / 2);
    localparam logic [11:0] FULL = 12'(BAUD_DIV);
`ifdef FRM_ERR_EN
    localparam bit CHECK_STOP = 1'b1;
`else
    localparam bit CHECK_STOP = 1'b0;
`endif

    logic       rx_s;
    logic       rx_prev_q;
    rx_state_e  state_q;
    logic [11:0] cnt_q;
    logic [2:0] bit_cnt_q;
    logic [8:0] shift_q;
    logic       done_q;
    logic [7:0] rx_data_q;
    logic       rdy_q;
    logic       expired;
`ifdef FRM_ERR_EN
    logic       frm_err_q;
`endif

    auth_rx_sync u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (RX),
        .q_o (rx_s)
    );

    assign expired = (cnt_q == 12'd1);

    // Stop bit lands in shift_q[8] and the byte in shift_q[7:0]; delivery happens
    // the cycle after the stop sample so IDLE can already accept the next edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_prev_q <= 1'b1;
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            done_q    <= 1'b0;
            rx_data_q <= '0;
            rdy_q     <= 1'b0;
`ifdef FRM_ERR_EN
            frm_err_q <= 1'b0;
`endif
        end else begin
            rx_prev_q <= rx_s;
            done_q    <= 1'b0;
`ifdef FRM_ERR_EN
            frm_err_q <= 1'b0;
`endif
            if (clr_rdy)
                rdy_q <= 1'b0;
            if (done_q) begin
                if (shift_q[8] || !CHECK_STOP) begin
                    rx_data_q <= shift_q[7:0];
                    rdy_q     <= 1'b1;
                end
`ifdef FRM_ERR_EN
                else
                    frm_err_q <= 1'b1;
`endif
            end
            case (state_q)
                IDLE: begin
                    if (rx_prev_q && !rx_s) begin
                        state_q <= START;
                        cnt_q   <= HALF;
                    end
                end
                START: begin
                    if (expired) begin
                        cnt_q <= FULL;
                        if (!rx_s) begin
                            state_q   <= DATA;
                            bit_cnt_q <= '0;
                            rdy_q     <= 1'b0;
                        end else begin
                            state_q <= IDLE;
                        end
                    end else begin
                        cnt_q <= cnt_q - 12'd1;
                    end
                end
                DATA: begin
                    if (expired) begin
                        cnt_q     <= FULL;
                        shift_q   <= {rx_s, shift_q[8:1]};
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7)
                            state_q <= STOP;
                    end else begin
                        cnt_q <= cnt_q - 12'd1;
                    end
                end
                STOP: begin
                    if (expired) begin
                        cnt_q   <= FULL;
                        shift_q <= {rx_s, shift_q[8:1]};
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q - 12'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rx_data = rx_data_q;
    assign rdy     = rdy_q;
`ifdef FRM_ERR_EN
    assign frm_err = frm_err_q;
`endif

endmodule

// File: tb/tb_auth_cmd_rx.sv
// tb_auth_cmd_rx: random and directed 8N1 frames checked against a byte-level
// model of what the consumer should see (define FRM_ERR_EN to cover framing errors).
module tb_auth_cmd_rx;
    import auth_pkg::*;

    localparam int B = 64;

    logic       clk = 1'b0;
    logic       rst;
    logic       RX;
    logic       clr_rdy;
    logic [7:0] rx_data;
    logic       rdy;
`ifdef FRM_ERR_EN
    logic       frm_err;
`endif

    int checks = 0;
    int errors = 0;
    int ferr_n = 0;
    int exp_ferr = 0;
    int lat;
    int gap;
    logic [7:0] exp_data;
    logic       exp_rdy;
    logic [7:0] d;
    logic       stop;
    logic       saw_rdy;

    always #5 clk = ~clk;

    auth_cmd_rx #(.BAUD_DIV(B)) dut (
        .clk     (clk),
        .rst     (rst),
        .RX      (RX),
        .clr_rdy (clr_rdy),
        .rx_data (rx_data),
        .rdy     (rdy)
`ifdef FRM_ERR_EN
        ,
        .frm_err (frm_err)
`endif
    );

`ifdef FRM_ERR_EN
    always @(negedge clk) if (frm_err) ferr_n++;
`endif

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tx_bit(input logic b);
        RX = b;
        repeat (B) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] v, input logic s);
        tx_bit(1'b0);
        for (int i = 0; i < 8; i++) tx_bit(v[i]);
        tx_bit(s);
    endtask

    task automatic idle(input int n);
        RX = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_clr();
        clr_rdy = 1'b1;
        @(posedge clk);
        #1;
        clr_rdy = 1'b0;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "_rdy"}, 32'(rdy), 32'(exp_rdy));
        check({tag, "_data"}, 32'(rx_data), 32'(exp_data));
`ifdef FRM_ERR_EN
        check({tag, "_ferr"}, 32'(ferr_n), 32'(exp_ferr));
`endif
    endtask

    initial begin
        rst = 1'b1;
        RX = 1'b1;
        clr_rdy = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        exp_data = 8'h00;
        exp_rdy = 1'b0;
        check_outputs("reset");
        check("reset_state", 32'(dut.state_q), 32'(IDLE));
        rst = 1'b0;
        idle(4);

        lat = 0;
        fork
            send_frame(AUTH_GO, 1'b1);
            begin
                while (!rdy && lat < 12 * B) begin
                    @(negedge clk);
                    lat++;
                end
            end
        join
        exp_data = AUTH_GO;
        exp_rdy = 1'b1;
        check_outputs("go");
        check("go_latency_max", 32'(lat <= (19 * B) / 2 + 5), 32'd1);
        check("go_latency_min", 32'(lat >= (19 * B) / 2), 32'd1);

        pulse_clr();
        @(negedge clk);
        exp_rdy = 1'b0;
        check_outputs("clr");

        RX = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        idle(2 * B);
        check_outputs("glitch");
        check("glitch_state", 32'(dut.state_q), 32'(IDLE));
        send_frame(AUTH_STOP, 1'b1);
        exp_data = AUTH_STOP;
        exp_rdy = 1'b1;
        check_outputs("after_glitch");

        pulse_clr();
        send_frame(AUTH_GO, 1'b1);
        send_frame(AUTH_STOP, 1'b1);
        exp_data = AUTH_STOP;
        exp_rdy = 1'b1;
        check_outputs("b2b");

        clr_rdy = 1'b1;
        saw_rdy = 1'b0;
        fork
            send_frame(8'hA5, 1'b1);
            repeat (10 * B - 2) begin
                @(negedge clk);
                if (rdy) saw_rdy = 1'b1;
            end
        join
        check("set_wins", 32'(saw_rdy), 32'd1);
        exp_data = 8'hA5;
        exp_rdy = 1'b0;
        check_outputs("set_then_clr");
        clr_rdy = 1'b0;
        idle(2);

`ifdef FRM_ERR_EN
        send_frame(8'h42, 1'b0);
        exp_ferr++;
        check_outputs("frm_err");
        idle(4);
`endif

        tx_bit(1'b0);
        for (int i = 0; i < 4; i++) tx_bit(AUTH_GO[i]);
        RX = AUTH_GO[4];
        repeat (B / 2) @(posedge clk);
        #1;
        rst = 1'b1;
        RX = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        exp_data = 8'h00;
        exp_rdy = 1'b0;
        check_outputs("mid_rst");
        rst = 1'b0;
        idle(12 * B);
        check_outputs("post_rst");
        check("post_rst_state", 32'(dut.state_q), 32'(IDLE));
        send_frame(AUTH_GO, 1'b1);
        exp_data = AUTH_GO;
        exp_rdy = 1'b1;
        check_outputs("rst_recover");
        idle(4);

        for (int k = 0; k < 16; k++) begin
            d = 8'($urandom);
            stop = ($urandom_range(0, 3) != 0);
            send_frame(d, stop);
`ifdef FRM_ERR_EN
            if (stop) begin
                exp_data = d;
                exp_rdy = 1'b1;
            end else begin
                exp_rdy = 1'b0;
                exp_ferr++;
            end
`else
            exp_data = d;
            exp_rdy = 1'b1;
`endif
            check_outputs("rand");
            gap = $urandom_range(0, 3) * (B / 2);
            if (!stop && gap < 4) gap = 4;
            if (gap > 0 && $urandom_range(0, 1) == 1) begin
                RX = 1'b1;
                pulse_clr();
                exp_rdy = 1'b0;
                check("rand_clr", 32'(rdy), 32'(exp_rdy));
                idle(gap - 1);
            end else begin
                idle(gap);
            end
        end
        idle(2);
        check_outputs("final");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
